// File: rtl/minority_pkg.sv
// Shared definitions for the minority-function sweep checker.
//
// Contents:
//   DEFAULT_WIDTH     default DUT input width
//   sweepState_e      checker FSM state encoding
//   minorityExpected  golden minority function, parameterised on width
package minority_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned MAX_WIDTH     = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweepState_e;

    // Returns 1 iff fewer than width/2 of the low 'width' bits of vec are set.
    // For width 4 this is true only for vectors with zero or one bits set.
    function automatic logic minorityExpected(input logic [MAX_WIDTH-1:0] vec,
                                              input int unsigned        width);
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                ones += 32'(vec[i]);
            end
        end
        return (ones < (width / 2));
    endfunction

endpackage

// File: rtl/minority_golden.sv
// Combinational golden model of the minority function.
//
// Ports:
//   vec_i       stimulus vector currently applied to the DUT
//   expected_o  1 iff popcount(vec_i) < WIDTH/2
module minority_golden
    import minority_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic             expected_o
);

    logic [MAX_WIDTH-1:0] vecWide;

    // The package helper works on a fixed-width vector; upper bits stay zero.
    assign vecWide    = MAX_WIDTH'(vec_i);
    assign expected_o = minorityExpected(vecWide, WIDTH);

endmodule

// File: rtl/minority_sweep_checker.sv
// On-chip response checker for a WIDTH-input minority function block.
//
// On START the checker drives every vector 0..2^WIDTH-1 to the DUT, holding
// each for SETTLE+1 cycles, samples DUT_IN on the last of those cycles and
// compares it with the golden minority function. Results persist in DONE
// until the next START or RST.
//
// Ports:
//   CLK             rising-edge clock
//   RST             synchronous active-high reset
//   START           begin a sweep; honoured only in IDLE or DONE
//   VEC_OUT         stimulus vector to the DUT
//   DUT_IN          DUT response
//   BUSY            high while sweeping
//   DONE            sweep complete, held until START or RST
//   PASS            valid with DONE; 1 iff ERR_COUNT == 0
//   ERR_COUNT       mismatches in the current/last sweep, saturating
//   FAIL_VALID      at least one mismatch captured
//   FIRST_FAIL_VEC  vector of the first mismatch
module minority_sweep_checker
    import minority_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned ERR_W  = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    output logic [WIDTH-1:0] VEC_OUT,
    input  logic             DUT_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_COUNT,
    output logic             FAIL_VALID,
    output logic [WIDTH-1:0] FIRST_FAIL_VEC
);

    // HOLD covers the first SETTLE cycles of each vector and SAMPLE the last
    // one, so each vector is driven for exactly SETTLE+1 cycles. With SETTLE=0
    // HOLD is skipped entirely and every cycle is a sample cycle.
    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam sweepState_e AFTER_VEC_STATE = (SETTLE == 0) ? ST_SAMPLE : ST_HOLD;

    sweepState_e      state;
    logic [CNT_W-1:0] settleCnt;

    logic             expected;
    logic             mismatch;
    logic             errSat;
    logic             lastVec;
    logic [ERR_W-1:0] errNext;

    minority_golden #(
        .WIDTH (WIDTH)
    ) uGolden (
        .vec_i      (VEC_OUT),
        .expected_o (expected)
    );

    always_comb begin
        mismatch = (DUT_IN != expected);
        errSat   = &ERR_COUNT;
        lastVec  = &VEC_OUT;
        errNext  = ERR_COUNT;
        if (mismatch && !errSat) begin
            errNext = ERR_COUNT + ERR_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= ST_IDLE;
            settleCnt      <= '0;
            VEC_OUT        <= '0;
            BUSY           <= 1'b0;
            DONE           <= 1'b0;
            PASS           <= 1'b0;
            ERR_COUNT      <= '0;
            FAIL_VALID     <= 1'b0;
            FIRST_FAIL_VEC <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    // Results stay visible in DONE until a new sweep starts.
                    if (START) begin
                        state          <= AFTER_VEC_STATE;
                        settleCnt      <= '0;
                        VEC_OUT        <= '0;
                        BUSY           <= 1'b1;
                        DONE           <= 1'b0;
                        PASS           <= 1'b0;
                        ERR_COUNT      <= '0;
                        FAIL_VALID     <= 1'b0;
                        FIRST_FAIL_VEC <= '0;
                    end
                end

                ST_HOLD: begin
                    if (settleCnt == SETTLE_LAST) begin
                        state     <= ST_SAMPLE;
                        settleCnt <= '0;
                    end else begin
                        settleCnt <= settleCnt + CNT_W'(1);
                    end
                end

                ST_SAMPLE: begin
                    ERR_COUNT <= errNext;
                    if (mismatch && !FAIL_VALID) begin
                        FAIL_VALID     <= 1'b1;
                        FIRST_FAIL_VEC <= VEC_OUT;
                    end
                    // The all-ones vector ends the sweep, so VEC_OUT never wraps.
                    if (lastVec) begin
                        state <= ST_DONE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        PASS  <= (errNext == '0);
                    end else begin
                        state     <= AFTER_VEC_STATE;
                        settleCnt <= '0;
                        VEC_OUT   <= VEC_OUT + WIDTH'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minority_sweep_checker.sv
// Bench for minority_sweep_checker. Three instances:
//   0: SETTLE=2, ERR_W=5   1: SETTLE=0, ERR_W=5   2: SETTLE=2, ERR_W=3
// The stimulus process queues the expected end-of-sweep result per START; a
// negedge monitor pops and compares whenever a DONE rises, and also checks
// vector sequencing and per-vector hold length while BUSY.
module tb_minority_sweep_checker;

    typedef struct {
        int         inst;
        int         startEdge;
        int         doneEdge;
        logic       pass;
        int         err;
        logic       fv;
        logic [3:0] first;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic [2:0]      start = '0;
    logic [2:0]      dutIn;
    logic [1:0]      mode [3];
    wire  [2:0][3:0] vec;
    wire  [2:0]      busy;
    wire  [2:0]      done;
    wire  [2:0]      pass;
    wire  [2:0][4:0] errCnt;
    wire  [2:0]      failValid;
    wire  [2:0][3:0] firstFail;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];

    always @(posedge clk) cyc <= cyc + 1;

    // DUT behaviour models: 0 correct, 1 stuck-at-0, 2 stuck-at-1, 3 inverted.
    function automatic logic modelOut(input logic [1:0] m, input logic [3:0] v);
        logic golden;
        golden = ($countones(v) < 2);
        case (m)
            2'd0:    return golden;
            2'd1:    return 1'b0;
            2'd2:    return 1'b1;
            default: return ~golden;
        endcase
    endfunction

    function automatic int settleOf(input int i);
        return (i == 1) ? 0 : 2;
    endfunction

    always_comb begin
        dutIn = '0;
        for (int i = 0; i < 3; i++) dutIn[i] = modelOut(mode[i], vec[i]);
    end

    minority_sweep_checker #(.WIDTH(4), .SETTLE(2), .ERR_W(5)) dut0 (
        .CLK(clk), .RST(rst), .START(start[0]), .VEC_OUT(vec[0]), .DUT_IN(dutIn[0]),
        .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]), .ERR_COUNT(errCnt[0]),
        .FAIL_VALID(failValid[0]), .FIRST_FAIL_VEC(firstFail[0])
    );

    minority_sweep_checker #(.WIDTH(4), .SETTLE(0), .ERR_W(5)) dut1 (
        .CLK(clk), .RST(rst), .START(start[1]), .VEC_OUT(vec[1]), .DUT_IN(dutIn[1]),
        .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]), .ERR_COUNT(errCnt[1]),
        .FAIL_VALID(failValid[1]), .FIRST_FAIL_VEC(firstFail[1])
    );

    minority_sweep_checker #(.WIDTH(4), .SETTLE(2), .ERR_W(3)) dut2 (
        .CLK(clk), .RST(rst), .START(start[2]), .VEC_OUT(vec[2]), .DUT_IN(dutIn[2]),
        .BUSY(busy[2]), .DONE(done[2]), .PASS(pass[2]), .ERR_COUNT(errCnt[2][2:0]),
        .FAIL_VALID(failValid[2]), .FIRST_FAIL_VEC(firstFail[2])
    );
    assign errCnt[2][4:3] = 2'b00;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic [2:0] prevBusy = '0;
    logic [2:0] prevDone = '0;
    int         busyRise [3];
    int         lastV [3];
    int         runLen [3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (busy[i] && !prevBusy[i]) begin
                busyRise[i] = cyc;
                lastV[i]    = vec[i];
                runLen[i]   = 1;
                check("first_vec", vec[i], 0);
            end else if (busy[i]) begin
                if (vec[i] == lastV[i]) begin
                    runLen[i]++;
                end else begin
                    check("hold_len", runLen[i], settleOf(i) + 1);
                    check("vec_step", vec[i], lastV[i] + 1);
                    lastV[i]  = vec[i];
                    runLen[i] = 1;
                end
                check("pass_low_while_busy", pass[i], 0);
            end
            if (done[i] && !prevDone[i]) begin
                if (expQ.size() == 0) begin
                    check("unexpected_done", i, -1);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    check("done_inst", i, e.inst);
                    check("busy_rise_edge", busyRise[i], e.startEdge);
                    check("done_edge", cyc, e.doneEdge);
                    check("busy_at_done", busy[i], 0);
                    check("pass", pass[i], e.pass);
                    check("err_count", errCnt[i], e.err);
                    check("fail_valid", failValid[i], e.fv);
                    check("first_fail_vec", firstFail[i], e.first);
                    check("last_vec", vec[i], 15);
                    check("last_hold_len", runLen[i], settleOf(i) + 1);
                end
            end
            prevBusy[i] = busy[i];
            prevDone[i] = done[i];
        end
    end

    // ---------------- stimulus ----------------
    task automatic checkIdleZero(input int i, input string tag);
        check({tag, "_vec"}, vec[i], 0);
        check({tag, "_busy"}, busy[i], 0);
        check({tag, "_done"}, done[i], 0);
        check({tag, "_pass"}, pass[i], 0);
        check({tag, "_err"}, errCnt[i], 0);
        check({tag, "_fv"}, failValid[i], 0);
        check({tag, "_first"}, firstFail[i], 0);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=pending%0d required=0", expQ.size());
            expQ.delete();
        end
    endtask

    // Issue START on instance i, queue the expected result, check the clear.
    task automatic launch(input int i, input logic [1:0] m, input logic p, input int err,
                          input logic fv, input logic [3:0] first);
        exp_t e;
        @(negedge clk);
        mode[i]     = m;
        start[i]    = 1'b1;
        e.inst      = i;
        e.startEdge = cyc + 1;
        e.doneEdge  = cyc + 1 + 16 * (settleOf(i) + 1);
        e.pass      = p;
        e.err       = err;
        e.fv        = fv;
        e.first     = first;
        expQ.push_back(e);
        @(negedge clk);
        start[i] = 1'b0;
        check("start_busy", busy[i], 1);
        check("start_done", done[i], 0);
        check("start_pass", pass[i], 0);
        check("start_vec", vec[i], 0);
        check("start_err", errCnt[i], 0);
        check("start_fv", failValid[i], 0);
        check("start_first", firstFail[i], 0);
    endtask

    task automatic waitVec(input int i, input int v);
        int n = 0;
        while (vec[i] != 4'(v) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_vec", vec[i], v);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) mode[i] = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) checkIdleZero(i, "reset");

        // Correct DUT, START sampled at edge 10, DONE at edge 58.
        while (cyc < 8) @(negedge clk);
        launch(0, 2'd0, 1'b1, 0, 1'b0, 4'd0);
        waitDrain();

        // Faulty DUT models.
        launch(0, 2'd1, 1'b0, 5, 1'b1, 4'b0000);
        waitDrain();
        launch(0, 2'd2, 1'b0, 11, 1'b1, 4'b0011);
        waitDrain();
        launch(0, 2'd3, 1'b0, 16, 1'b1, 4'b0000);
        waitDrain();
        launch(2, 2'd3, 1'b0, 7, 1'b1, 4'b0000);
        waitDrain();

        // Reset in the middle of a sweep, then a fresh run.
        @(negedge clk);
        mode[0]  = 2'd1;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        waitVec(0, 6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkIdleZero(0, "mid_reset");
        launch(0, 2'd0, 1'b1, 0, 1'b0, 4'd0);
        waitDrain();

        // START while busy must be ignored.
        launch(0, 2'd2, 1'b0, 11, 1'b1, 4'b0011);
        waitVec(0, 4);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        waitDrain();

        // SETTLE=0: failing run, then restart from DONE with a correct DUT.
        launch(1, 2'd1, 1'b0, 5, 1'b1, 4'b0000);
        waitDrain();
        launch(1, 2'd0, 1'b1, 0, 1'b0, 4'd0);
        waitDrain();
        launch(1, 2'd2, 1'b0, 11, 1'b1, 4'b0011);
        waitDrain();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
